// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Contents:
//   MUL_LATENCY     issue-to-result latency in cycles
//   DEF_*_WIDTH     default operand/result widths
//   MAX_REQ         largest supported requester count
//   rr_pick()       round-robin one-hot grant selection
package mul_share_pkg;

    localparam int MUL_LATENCY    = 2;
    localparam int DEF_DIN_WIDTH  = 17;
    localparam int DEF_DOUT_WIDTH = 32;
    localparam int MAX_REQ        = 8;

    // Search starts one past the last granted index and wraps modulo n.
    // The first valid requester found gets the grant. Returns zero if no
    // requester is valid. Bits at and above n are always zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic [2:0]         idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = 3'((int'(ptr) + k) % n);
                if (!found && valid[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mul_share_core.sv
// Combinational signed multiply with truncation to DOUT_WIDTH bits.
// Ports:
//   din0, din1  signed two's-complement operands (DIN_WIDTH)
//   dout        low DOUT_WIDTH bits of the signed product
module mul_share_core
    import mul_share_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic [DIN_WIDTH-1:0]  din0,
    input  logic [DIN_WIDTH-1:0]  din1,
    output logic [DOUT_WIDTH-1:0] dout
);

    // The low DOUT_WIDTH bits of a product depend only on the low
    // DOUT_WIDTH bits of the sign-extended operands. Multiplying at
    // max(DIN_WIDTH, DOUT_WIDTH) therefore gives the same bits as the full
    // 2*DIN_WIDTH product truncated, and no product bit is wasted.
    localparam int PW = (DOUT_WIDTH > DIN_WIDTH) ? DOUT_WIDTH : DIN_WIDTH;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;

    assign a_ext = PW'($signed(din0));
    assign b_ext = PW'($signed(din1));
    assign prod  = a_ext * b_ext;
    assign dout  = prod[DOUT_WIDTH-1:0];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one signed multiplier among NUM_REQ requesters.
// Operation path: one grant per cycle, a stage-1 issue register, then a
// stage-2 product register. The result pulses back to the issuing
// requester two cycles after the grant.
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   en                  grant enable; in-flight operations drain when low
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        packed operands, DIN_WIDTH bits per requester
//   rsp_valid/rsp_data  one-cycle result pulse to the issuing requester
//   busy                an operation is in stage 1 or stage 2
//   op_count            completed operations; wraps
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DOUT_WIDTH-1:0]        rsp_data,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         op_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      gnt_idx;
    logic [MAX_REQ-1:0]    valid_ext;
    logic                  xfer;
    logic [DIN_WIDTH-1:0]  sel_a, sel_b;

    logic                  s1_vld;
    logic [NUM_REQ-1:0]    s1_id;
    logic [DIN_WIDTH-1:0]  s1_a, s1_b;

    logic                  s2_vld;
    logic [NUM_REQ-1:0]    s2_id;
    logic [DOUT_WIDTH-1:0] s2_data;
    logic [DOUT_WIDTH-1:0] prod;

    // Grant logic. Reset and en both mask the grant so that no transfer
    // can occur in a reset cycle or while draining.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        req_ready = (en && !ap_rst)
                  ? NUM_REQ'(rr_pick(valid_ext, 3'(rr_ptr), NUM_REQ))
                  : '0;
    end

    // req_ready is only ever high for a valid requester, so any ready bit
    // means a transfer.
    assign xfer = |req_ready;

    // Encode the one-hot grant and steer the winner's operands.
    always_comb begin
        gnt_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx = PTR_W'(i);
                sel_a   = req_a[i*DIN_WIDTH +: DIN_WIDTH];
                sel_b   = req_b[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    mul_share_core #(
        .DIN_WIDTH  (DIN_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_core (
        .din0 (s1_a),
        .din1 (s1_b),
        .dout (prod)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr   <= PTR_W'(NUM_REQ - 1);
            s1_vld   <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_vld   <= 1'b0;
            s2_id    <= '0;
            s2_data  <= '0;
            op_count <= '0;
        end else begin
            s1_vld <= xfer;
            if (xfer) begin
                rr_ptr <= gnt_idx;
                s1_id  <= req_ready;
                s1_a   <= sel_a;
                s1_b   <= sel_b;
            end
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
            // Load only on a real operation so rsp_data holds the last result.
            if (s1_vld) s2_data <= prod;
            if (s2_vld) op_count <= op_count + CNT_WIDTH'(1);
        end
    end

    assign rsp_valid = s2_vld ? s2_id : '0;
    assign rsp_data  = s2_data;
    assign busy      = s1_vld | s2_vld;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (NUM_REQ=4).
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 17;
    localparam int OW = 32;
    localparam int CW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]  rsp_valid;
    logic [OW-1:0] rsp_data;
    logic          busy;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] exp;
        string         name;
    } vec_t;

    vec_t          tv[8];
    logic [OW-1:0] exp_rr[4];

    mul_share_arbiter #(
        .NUM_REQ    (N),
        .DIN_WIDTH  (DW),
        .DOUT_WIDTH (OW),
        .CNT_WIDTH  (CW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    initial begin
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rsp;

        tv[0] = '{17'd3,     17'h1FFFB, 32'hFFFFFFF1, "3x-5"};
        tv[1] = '{17'h10000, 17'h10000, 32'h00000000, "min_x_min"};
        tv[2] = '{17'h0FFFF, 17'h0FFFF, 32'hFFFE0001, "max_x_max"};
        tv[3] = '{17'h10000, 17'd1,     32'hFFFF0000, "min_x_1"};
        tv[4] = '{17'h1FFFF, 17'h1FFFF, 32'h00000001, "m1_x_m1"};
        tv[5] = '{17'h10000, 17'h0FFFF, 32'h00010000, "min_x_max"};
        tv[6] = '{17'h03039, 17'h1FFFE, 32'hFFFF9F8E, "12345_x_m2"};
        tv[7] = '{17'd0,     17'h10000, 32'h00000000, "zero_x_min"};
        exp_rr = '{32'hFFFFFFFE, 32'hFFFFFFFA, 32'hFFFFFFF4, 32'hFFFFFFEC};

        // Reset: ready must stay low even with every requester valid.
        ap_rst    = 1'b1;
        en        = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        req_valid = '0;
        ap_rst    = 1'b0;

        // Single requester 2: 3 * -5.
        set_op(2, 17'd3, 17'h1FFFB);
        req_valid = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1 chk("single_c1_rsp", rsp_valid, 0);
        chk("single_c1_busy", busy, 1);
        tick();
        chk("single_c2_rsp", rsp_valid, 4'b0100);
        chk("single_c2_data", rsp_data, 32'hFFFFFFF1);
        tick();
        chk("single_op_count", op_count, 1);
        chk("single_idle", busy, 0);
        chk("single_c3_rsp", rsp_valid, 0);

        // Truncation table on requester 0; each issue overlaps the prior result.
        for (int v = 0; v < 8; v++) begin
            set_op(0, tv[v].a, tv[v].b);
            req_valid = 4'b0001;
            #1 chk({"tv_ready_", tv[v].name}, req_ready, 4'b0001);
            tick();
            req_valid = '0;
            tick();
            chk({"tv_rsp_", tv[v].name}, rsp_valid, 4'b0001);
            chk({"tv_data_", tv[v].name}, rsp_data, tv[v].exp);
        end
        tick();
        chk("tv_op_count", op_count, 9);
        chk("tv_data_hold", rsp_data, tv[7].exp);

        // All four valid from reset: grants 0,1,2,3,... and results 2 later.
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("rr_op_count_cleared", op_count, 0);
        for (int i = 0; i < N; i++) set_op(i, 17'(i + 2), 17'(-(i + 1)));
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = '0;
            #1;
            e_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
            e_rsp = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
            chk($sformatf("rr_ready_c%0d", k), req_ready, e_rdy);
            chk($sformatf("rr_rsp_c%0d", k), rsp_valid, e_rsp);
            if (e_rsp != 0)
                chk($sformatf("rr_data_c%0d", k), rsp_data, exp_rr[(k - 2) % 4]);
            tick();
        end

        // Sparse: set rr_ptr=1, then only 1 and 3 valid -> 3,1,3,1,...
        req_valid = 4'b0010;
        #1 chk("sparse_seed", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            #1;
            e_rdy = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            chk($sformatf("sparse_ready_%0d", k), req_ready, e_rdy);
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        // en drop with rr_ptr=1: grants 2 then 3, then drain.
        req_valid = 4'b1111;
        #1 chk("en_c0_ready", req_ready, 4'b0100);
        tick();
        chk("en_c1_ready", req_ready, 4'b1000);
        chk("en_c1_busy", busy, 1);
        tick();
        en = 1'b0;
        #1 chk("en_c2_ready", req_ready, 0);
        chk("en_c2_rsp", rsp_valid, 4'b0100);
        chk("en_c2_data", rsp_data, exp_rr[2]);
        tick();
        chk("en_c3_ready", req_ready, 0);
        chk("en_c3_rsp", rsp_valid, 4'b1000);
        chk("en_c3_data", rsp_data, exp_rr[3]);
        tick();
        chk("en_c4_busy", busy, 0);
        chk("en_c4_rsp", rsp_valid, 0);
        chk("en_c4_ready", req_ready, 0);
        tick();
        chk("en_c5_busy", busy, 0);
        req_valid = '0;
        en        = 1'b1;

        // Reset mid-flight: move rr_ptr off its reset value first.
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 4'b0100;
        #1 chk("mid_c0_ready", req_ready, 4'b0100);
        tick();
        ap_rst = 1'b1;
        #1 chk("mid_c1_ready_in_rst", req_ready, 0);
        tick();
        ap_rst    = 1'b0;
        req_valid = '0;
        #1 chk("mid_c2_rsp", rsp_valid, 0);
        chk("mid_c2_busy", busy, 0);
        chk("mid_c2_op_count", op_count, 0);
        chk("mid_c2_data", rsp_data, 0);
        tick();
        chk("mid_c3_rsp", rsp_valid, 0);
        req_valid = 4'b1111;
        #1 chk("mid_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("mid_final_op_count", op_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
